alu_cmd_initiator: RTL and testbench

ALU_CMD_INITIATOR -- requirements
Module: alu_cmd_initiator

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_cmd_fifo.sv | 63 ++++++
 rtl/alu_cmd_initiator.sv | 160 ++++++++++++++++
 tb/tb_alu_cmd_initiator.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU command initiator: opcodes, FSM states and the
// command record carried through the command FIFO.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_AND = 3'd2,
        ALU_XOR = 3'd3,
        ALU_MUL = 3'd4,
        ALU_RST = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_NOP   = 2'd2,
        S_GAP   = 2'd3
    } alu_state_e;

    typedef struct packed {
        alu_op_e    op;
        logic [7:0] a;
        logic [7:0] b;
    } alu_cmd_t;

    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO holding alu_cmd_t entries; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate count.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  alu_cmd_t push_data,
    input  logic     pop,
    output alu_cmd_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    alu_cmd_t       mem_q [DEPTH];
    alu_cmd_t       mem_d [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           push_ok, pop_ok;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // A write into a full FIFO is legal only when the head leaves the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/alu_cmd_initiator.sv
// Pops queued commands and drives them to an ALU with a start/done handshake,
// returning one response per non-NOP command (result or timeout).
module alu_cmd_initiator
    import alu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CKS = 64
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        start,
    output logic [2:0]  op,
    output logic [7:0]  A,
    output logic [7:0]  B,
    input  logic        done,
    input  logic [15:0] result,
    output logic        rsp_valid,
    output logic [15:0] rsp_result,
    output logic        rsp_timeout,
    output logic        proto_err,
    output alu_state_e  dbg_state
);

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CKS);

    alu_state_e       state_q, state_d;
    logic             start_q, start_d;
    logic [2:0]       op_q, op_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [15:0]      rsp_result_q, rsp_result_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic             proto_err_q, proto_err_d;
    logic             ready_en_q;

    alu_cmd_t         cmd_in, cmd_head;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] cnt_inc;

    assign cmd_in    = '{op: alu_op_e'(cmd_op), a: cmd_a, b: cmd_b};
    // Keeps cmd_ready low while reset is held and for the edge it releases on.
    assign cmd_ready = ready_en_q && (!fifo_full || fifo_pop);
    assign fifo_push = cmd_valid && cmd_ready;
    assign cnt_inc   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .pop_data  (cmd_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        start_d       = start_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_result_d  = rsp_result_q;
        rsp_timeout_d = 1'b0;
        fifo_pop      = 1'b0;
        proto_err_d   = proto_err_q | (done & ~start_q);

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = cmd_head.op;
                    a_d      = cmd_head.a;
                    b_d      = cmd_head.b;
                    start_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = (cmd_head.op == ALU_NOP) ? S_NOP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_inc;
                // done wins over a timeout that lands in the same cycle.
                if (done) begin
                    start_d      = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = result;
                    state_d      = S_GAP;
                end else if (cnt_inc == TO_LIMIT) begin
                    start_d       = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_result_d  = '0;
                    state_d       = S_GAP;
                end
            end
            S_NOP: begin
                start_d = 1'b0;
                state_d = S_GAP;
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                start_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b0;
            proto_err_q   <= 1'b0;
            ready_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_timeout_q <= rsp_timeout_d;
            proto_err_q   <= proto_err_d;
            ready_en_q    <= 1'b1;
        end
    end

    assign start       = start_q;
    assign op          = op_q;
    assign A           = a_q;
    assign B           = b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_timeout = rsp_timeout_q;
    assign proto_err   = proto_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Directed bench for alu_cmd_initiator: plays the ALU responder by hand and
// checks every response, FIFO back-pressure, timeout and reset behaviour.
module tb_alu_cmd_initiator;
    import alu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        done;
    logic [15:0] result;
    logic        rsp_valid;
    logic [15:0] rsp_result;
    logic        rsp_timeout;
    logic        proto_err;
    alu_state_e  dbg_state;

    int          n_checks;
    int          n_fail;
    logic        chk_en;
    logic        prev_nop_start;
    logic        prev_done;
    logic [18:0] exp_q[$];

    alu_cmd_initiator #(
        .FIFO_DEPTH  (4),
        .TIMEOUT_CKS (64)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .done        (done),
        .result      (result),
        .rsp_valid   (rsp_valid),
        .rsp_result  (rsp_result),
        .rsp_timeout (rsp_timeout),
        .proto_err   (proto_err),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // ALU-side protocol rules, sampled on the falling edge.
    task automatic proto_check();
        if (reset_n && chk_en) begin
            chk("proto_done_implies_start", 32'(done && !start), 32'd0);
            chk("proto_no_done_after_nop", 32'(done && prev_nop_start), 32'd0);
            chk("proto_done_width", 32'(done && prev_done), 32'd0);
        end
        prev_nop_start = start && (op == 3'd0);
        prev_done      = done;
    endtask

    task automatic tick();
        @(negedge clk);
        proto_check();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] alu_model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic drive_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_op    = o;
        cmd_a     = a;
        cmd_b     = b;
    endtask

    // Waits for the next start, checks it against the expected order and answers it.
    task automatic serve();
        logic [18:0] e;
        int          w;
        w = 0;
        while (start !== 1'b1 && w < 20) begin
            w++;
            tick();
        end
        chk("serve_start_seen", 32'(start), 32'd1);
        chk("serve_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("serve_op", 32'(op), 32'(e[18:16]));
            chk("serve_a", 32'(A), 32'(e[15:8]));
            chk("serve_b", 32'(B), 32'(e[7:0]));
            if (e[18:16] == 3'd0) begin
                tick();
                chk("serve_nop_start_low", 32'(start), 32'd0);
                chk("serve_nop_no_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                tick();
                done   = 1'b1;
                result = alu_model(e[18:16], e[15:8], e[7:0]);
                tick();
                done   = 1'b0;
                chk("serve_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("serve_rsp_result", 32'(rsp_result), 32'(alu_model(e[18:16], e[15:8], e[7:0])));
                chk("serve_rsp_timeout", 32'(rsp_timeout), 32'd0);
                chk("serve_start_drop", 32'(start), 32'd0);
            end
        end
    endtask

    initial begin
        int n;
        n_checks       = 0;
        n_fail         = 0;
        chk_en         = 1'b1;
        prev_nop_start = 1'b0;
        prev_done      = 1'b0;
        reset_n        = 1'b0;
        cmd_valid      = 1'b0;
        cmd_op         = 3'd0;
        cmd_a          = 8'h00;
        cmd_b          = 8'h00;
        done           = 1'b0;
        result         = 16'h0000;

        // Reset values while reset is held.
        #3;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_op_a_b", {8'h00, 5'(op), A, B}, 32'd0);
        chk("rst_rsp", {14'h0, rsp_valid, rsp_timeout, rsp_result}, 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        tick();
        reset_n = 1'b1;
        chk("rel_cmd_ready_before_clk", 32'(cmd_ready), 32'd0);
        tick();
        chk("rel_cmd_ready_after_clk", 32'(cmd_ready), 32'd1);

        // ADD 5+3, done in the third start cycle.
        drive_cmd(3'd1, 8'h05, 8'h03);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("add_start_c1", 32'(start), 32'd1);
        chk("add_op", 32'(op), 32'd1);
        chk("add_a_b", {16'h0, A, B}, 32'h0503);
        chk("add_state_issue", 32'(dbg_state), 32'd1);
        tick();
        chk("add_start_c2", 32'(start), 32'd1);
        tick();
        chk("add_start_c3", 32'(start), 32'd1);
        done   = 1'b1;
        result = 16'h0008;
        tick();
        done   = 1'b0;
        chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("add_rsp_result", 32'(rsp_result), 32'h0008);
        chk("add_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("add_start_drop", 32'(start), 32'd0);
        chk("add_hold_op_a_b", {13'h0, op, A, B}, 32'h0010503);
        tick();
        chk("add_rsp_pulse_end", 32'(rsp_valid), 32'd0);
        chk("add_back_idle", 32'(dbg_state), 32'd0);

        // NOP followed by MUL FF*FF.
        drive_cmd(3'd0, 8'h11, 8'h22);
        tick();
        drive_cmd(3'd4, 8'hFF, 8'hFF);
        tick();
        cmd_valid = 1'b0;
        chk("nop_start", 32'(start), 32'd1);
        chk("nop_op", 32'(op), 32'd0);
        tick();
        chk("nop_start_one_cycle", 32'(start), 32'd0);
        chk("nop_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        chk("nop_gap_start_low", 32'(start), 32'd0);
        chk("nop_gap_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        chk("mul_start", 32'(start), 32'd1);
        chk("mul_op_a_b", {13'h0, op, A, B}, 32'h004FFFF);
        done   = 1'b1;
        result = 16'hFE01;
        tick();
        done   = 1'b0;
        chk("mul_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("mul_rsp_result", 32'(rsp_result), 32'h0000FE01);
        tick();

        // XOR never answered: times out after 64 start cycles; AND queued behind it.
        drive_cmd(3'd3, 8'h0F, 8'hF0);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("to_start", 32'(start), 32'd1);
        drive_cmd(3'd2, 8'h3C, 8'h0F);
        tick();
        cmd_valid = 1'b0;
        n = 1;
        while (start === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk("to_start_cycles", 32'(n), 32'd64);
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
        chk("to_rsp_result", 32'(rsp_result), 32'd0);
        tick();
        chk("to_gap_start_low", 32'(start), 32'd0);
        chk("to_rsp_pulse_end", 32'(rsp_valid), 32'd0);
        tick();
        chk("to_next_start", 32'(start), 32'd1);
        chk("to_next_op", 32'(op), 32'd2);

        // AND answered in the 64th start cycle: completion, not timeout.
        for (int i = 0; i < 63; i++) begin
            tick();
        end
        chk("edge_start_c64", 32'(start), 32'd1);
        done   = 1'b1;
        result = 16'h000C;
        tick();
        done   = 1'b0;
        chk("edge_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("edge_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("edge_rsp_result", 32'(rsp_result), 32'h000C);
        tick();
        tick();

        // FIFO full: one command in ISSUE, four queued, fifth held off until a pop.
        drive_cmd(3'd1, 8'h10, 8'h20);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("full_c0_start", 32'(start), 32'd1);
        drive_cmd(3'd3, 8'hAA, 8'h55); exp_q.push_back({3'd3, 8'hAA, 8'h55}); tick();
        drive_cmd(3'd4, 8'h12, 8'h34); exp_q.push_back({3'd4, 8'h12, 8'h34}); tick();
        drive_cmd(3'd2, 8'hF0, 8'h3C); exp_q.push_back({3'd2, 8'hF0, 8'h3C}); tick();
        drive_cmd(3'd1, 8'hFF, 8'h01); exp_q.push_back({3'd1, 8'hFF, 8'h01}); tick();
        drive_cmd(3'd0, 8'h01, 8'h02);
        chk("full_ready_low", 32'(cmd_ready), 32'd0);
        tick();
        chk("full_ready_still_low", 32'(cmd_ready), 32'd0);
        done   = 1'b1;
        result = 16'h0030;
        tick();
        done   = 1'b0;
        chk("full_c0_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("full_c0_rsp_result", 32'(rsp_result), 32'h0030);
        chk("full_gap_ready_low", 32'(cmd_ready), 32'd0);
        tick();
        chk("full_pop_ready_high", 32'(cmd_ready), 32'd1);
        exp_q.push_back({3'd0, 8'h01, 8'h02});
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            serve();
        end
        chk("full_all_served", 32'(exp_q.size()), 32'd0);
        tick();
        tick();

        // done with start low sets the sticky protocol error.
        chk("perr_clear_before", 32'(proto_err), 32'd0);
        chk_en = 1'b0;
        done   = 1'b1;
        tick();
        done   = 1'b0;
        chk_en = 1'b1;
        chk("perr_set", 32'(proto_err), 32'd1);
        chk("perr_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        tick();
        tick();
        chk("perr_sticky", 32'(proto_err), 32'd1);

        // Reset in the middle of an ISSUE with another command queued.
        drive_cmd(3'd1, 8'h01, 8'h02);
        tick();
        drive_cmd(3'd3, 8'h0A, 8'h0B);
        tick();
        cmd_valid = 1'b0;
        chk("mid_rst_start_before", 32'(start), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_start_async", 32'(start), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_proto_err", 32'(proto_err), 32'd0);
        chk("mid_rst_op_a_b", {13'h0, op, A, B}, 32'd0);
        #2;
        reset_n = 1'b1;
        tick();
        chk("mid_rst_ready_after_clk", 32'(cmd_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (start === 1'b1 || rsp_valid === 1'b1) n++;
            tick();
        end
        chk("mid_rst_queue_flushed", 32'(n), 32'd0);
        chk("mid_rst_idle", 32'(dbg_state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
